// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// Request: req/we/addr/wdata/be from the master; completion: ack/rdata back.
interface mem_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_be_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_be_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while an
// access is outstanding, formats load data and flags misalign/bus errors.
// Ports: clk_i, rst_i (async, active-low); mem (mem_stage_if.master);
//   EX/MEM controls d_memread_i/d_memwrite_i/d_memtoreg_i/d_regwrite_i,
//   regdst_i, alu_result_i, write_data_i, size_i, sign_ext_i;
//   stall_o to upstream; d_memtoreg_o/d_regwrite_o/regdst_o/data_mem_o/
//   alu_result_o to MEM/WB; misalign_o/bus_err_o exception pulses.
// Config: define MEM_BYTE_ACCESS_EN for byte/half accesses; otherwise every
//   access is a full word with all byte enables set.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mem_stage_if.master mem,
    input  logic        d_memread_i,
    input  logic        d_memwrite_i,
    input  logic        d_memtoreg_i,
    input  logic        d_regwrite_i,
    input  logic [4:0]  regdst_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] write_data_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic        stall_o,
    output logic        d_memtoreg_o,
    output logic        d_regwrite_o,
    output logic [4:0]  regdst_o,
    output logic [31:0] data_mem_o,
    output logic [31:0] alu_result_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        bus_err_q, bus_err_d;

    logic        access;
    logic        misalign;
    logic        start;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] load_fmt;

    assign access = d_memread_i | d_memwrite_i;
    assign start  = (state_q == IDLE) & access & ~misalign;

`ifdef MEM_BYTE_ACCESS_EN
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] shifted;

    always_comb begin
        misalign = 1'b0;
        be_n     = 4'hF;
        wdata_n  = write_data_i;
        unique case (1'b1)
            size_i == 2'b00: begin
                be_n    = 4'b0001 << alu_result_i[1:0];
                wdata_n = {4{write_data_i[7:0]}};
            end
            size_i == 2'b01: begin
                misalign = alu_result_i[0];
                be_n     = 4'b0011 << alu_result_i[1:0];
                wdata_n  = {2{write_data_i[15:0]}};
            end
            default: begin
                misalign = |alu_result_i[1:0];
            end
        endcase
    end

    // Selected lane is moved down to bit 0 before extension.
    always_comb begin
        shifted  = mem.mem_rdata_i >> {addr_q[1:0], 3'b000};
        load_fmt = mem.mem_rdata_i;
        unique case (1'b1)
            size_q == 2'b00:
                load_fmt = sext_q ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'h0, shifted[7:0]};
            size_q == 2'b01:
                load_fmt = sext_q ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'h0, shifted[15:0]};
            default: load_fmt = mem.mem_rdata_i;
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{size_i, sign_ext_i};
    assign misalign   = |alu_result_i[1:0];
    assign be_n       = 4'hF;
    assign wdata_n    = write_data_i;
    assign load_fmt   = mem.mem_rdata_i;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        bus_err_d = 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
        size_d    = size_q;
        sext_d    = sext_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = 5'd0;
                    req_d   = 1'b1;
                    // read+write together is a store
                    we_d    = d_memwrite_i;
                    addr_d  = alu_result_i;
                    wdata_d = wdata_n;
                    be_d    = be_n;
`ifdef MEM_BYTE_ACCESS_EN
                    size_d  = size_i;
                    sext_d  = sign_ext_i;
`endif
                end
            end
            WAIT: begin
                // ack wins over a timeout in the same cycle
                if (mem.mem_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        buf_d = load_fmt;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    buf_d     = 32'h0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            buf_q     <= 32'h0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            bus_err_q <= 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
            size_q    <= 2'b10;
            sext_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            bus_err_q <= bus_err_d;
`ifdef MEM_BYTE_ACCESS_EN
            size_q    <= size_d;
            sext_q    <= sext_d;
`endif
        end
    end

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_be_o    = be_q;

    assign stall_o      = rst_i & (start | (state_q == WAIT));
    assign misalign_o   = (state_q == IDLE) & access & misalign;
    assign bus_err_o    = bus_err_q;
    assign d_memtoreg_o = d_memtoreg_i;
    assign d_regwrite_o = d_regwrite_i & ~misalign_o
                        & ~((state_q == DONE) & bus_err_q);
    assign regdst_o     = regdst_i;
    assign alu_result_o = alu_result_i;
    assign data_mem_o   = (state_q == DONE) ? buf_q : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM/WB captures,
// a monitor pops and compares on every non-stalled cycle.
module tb_mem_stage;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mem_stage_if mem();

    logic        d_memread_i, d_memwrite_i, d_memtoreg_i, d_regwrite_i;
    logic [4:0]  regdst_i;
    logic [31:0] alu_result_i, write_data_i;
    logic [1:0]  size_i;
    logic        sign_ext_i;
    logic        stall_o, d_memtoreg_o, d_regwrite_o;
    logic [4:0]  regdst_o;
    logic [31:0] data_mem_o, alu_result_o;
    logic        misalign_o, bus_err_o;

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .mem(mem),
        .d_memread_i(d_memread_i),
        .d_memwrite_i(d_memwrite_i),
        .d_memtoreg_i(d_memtoreg_i),
        .d_regwrite_i(d_regwrite_i),
        .regdst_i(regdst_i),
        .alu_result_i(alu_result_i),
        .write_data_i(write_data_i),
        .size_i(size_i),
        .sign_ext_i(sign_ext_i),
        .stall_o(stall_o),
        .d_memtoreg_o(d_memtoreg_o),
        .d_regwrite_o(d_regwrite_o),
        .regdst_o(regdst_o),
        .data_mem_o(data_mem_o),
        .alu_result_o(alu_result_o),
        .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    typedef struct {
        int          id;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int op_id = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic mon_en = 1'b0;

    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, want);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i || !mon_en) begin
            stall_cnt = 0;
            req_cnt = 0;
        end else begin
            if (mem.mem_req_o) begin
                req_cnt++;
                chk("bus_we", {31'h0, mem.mem_we_o}, {31'h0, exp_we});
                chk("bus_addr", mem.mem_addr_o, exp_addr);
                chk("bus_wdata", mem.mem_wdata_o, exp_wdata);
                chk("bus_be", {28'h0, mem.mem_be_o}, {28'h0, exp_be});
            end
            if (stall_o) begin
                stall_cnt++;
            end else if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("op%0d_alu", e.id), alu_result_o, e.alu);
                chk($sformatf("op%0d_rd", e.id), {27'h0, regdst_o},
                    {27'h0, e.rd});
                chk($sformatf("op%0d_m2r", e.id), {31'h0, d_memtoreg_o},
                    {31'h0, e.m2r});
                chk($sformatf("op%0d_rw", e.id), {31'h0, d_regwrite_o},
                    {31'h0, e.rw});
                chk($sformatf("op%0d_mis", e.id), {31'h0, misalign_o},
                    {31'h0, e.mis});
                chk($sformatf("op%0d_berr", e.id), {31'h0, bus_err_o},
                    {31'h0, e.berr});
                chk($sformatf("op%0d_stalls", e.id), stall_cnt, e.stalls);
                chk($sformatf("op%0d_reqs", e.id), req_cnt, e.reqs);
                if (e.chk_data)
                    chk($sformatf("op%0d_data", e.id), data_mem_o, e.data);
                stall_cnt = 0;
                req_cnt = 0;
            end else begin
                stall_cnt = 0;
                req_cnt = 0;
            end
        end
    end

    task automatic drive_nop();
        d_memread_i = 1'b0;
        d_memwrite_i = 1'b0;
        d_memtoreg_i = 1'b0;
        d_regwrite_i = 1'b0;
        regdst_i = 5'd0;
        alu_result_i = 32'h0;
        write_data_i = 32'h0;
        size_i = 2'b10;
        sign_ext_i = 1'b0;
        mem.mem_ack_i = 1'b0;
        mem.mem_rdata_i = 32'h0;
    endtask

    // ack_wait: WAIT cycle (1-based) on which ack is driven, 0 = never.
    // early: also drive ack in the IDLE cycle, which must be ignored.
    task automatic run_op(
        input logic rd_i, input logic wr_i,
        input logic m2r_i, input logic rw_i,
        input logic [4:0] dst, input logic [31:0] alu,
        input logic [31:0] wd, input logic [1:0] sz, input logic sx,
        input int ack_wait, input logic [31:0] rdata, input logic early,
        input logic [31:0] e_data, input logic e_chk,
        input logic e_rw, input logic e_mis, input logic e_berr,
        input int e_st, input int e_rq,
        input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wd);
        exp_t e;
        int n;
        int nw;
        @(posedge clk_i);
        #1;
        d_memread_i = rd_i;
        d_memwrite_i = wr_i;
        d_memtoreg_i = m2r_i;
        d_regwrite_i = rw_i;
        regdst_i = dst;
        alu_result_i = alu;
        write_data_i = wd;
        size_i = sz;
        sign_ext_i = sx;
        mem.mem_ack_i = early;
        mem.mem_rdata_i = 32'hFFFF_FFFF;
        exp_we = e_we;
        exp_addr = alu;
        exp_wdata = e_wd;
        exp_be = e_be;
        op_id++;
        e.id = op_id;
        e.alu = alu;
        e.rd = dst;
        e.m2r = m2r_i;
        e.rw = e_rw;
        e.data = e_data;
        e.chk_data = e_chk;
        e.mis = e_mis;
        e.berr = e_berr;
        e.stalls = e_st;
        e.reqs = e_rq;
        sb.push_back(e);
        n = 0;
        nw = 0;
        #1;
        while (stall_o && n < 64) begin
            @(posedge clk_i);
            #1;
            n++;
            if (mem.mem_req_o) nw++;
            mem.mem_ack_i = mem.mem_req_o && ack_wait != 0 && nw == ack_wait;
            mem.mem_rdata_i = rdata;
            #1;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL op%0d_hang: stall still 1 after %0d cycles",
                     op_id, n);
        end
    endtask

    initial begin
        drive_nop();
        d_memread_i = 1'b1;
        d_regwrite_i = 1'b1;
        alu_result_i = 32'h100;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_req", {31'h0, mem.mem_req_o}, 32'h0);
        chk("rst_we", {31'h0, mem.mem_we_o}, 32'h0);
        chk("rst_berr", {31'h0, bus_err_o}, 32'h0);
        chk("rst_data", data_mem_o, 32'h0);
        drive_nop();
        @(negedge clk_i);
        rst_i = 1'b1;
        mon_en = 1'b1;

        // non-memory pass-through
        run_op(0, 0, 0, 1, 5'd5, 32'h1234_5678, 32'h0, 2'b10, 0,
               0, 32'h0, 0,
               32'h0, 1, 1, 0, 0, 0, 0, 0, 4'hF, 32'h0);
        // word load, ack on second WAIT cycle
        run_op(1, 0, 1, 1, 5'd7, 32'h100, 32'h0, 2'b10, 0,
               2, 32'hDEAD_BEEF, 0,
               32'hDEAD_BEEF, 1, 1, 0, 0, 3, 2, 0, 4'hF, 32'h0);
        // word store, ack on first WAIT cycle
        run_op(0, 1, 0, 0, 5'd0, 32'h104, 32'hCAFE_F00D, 2'b10, 0,
               1, 32'h0, 0,
               32'h0, 0, 0, 0, 0, 2, 1, 1, 4'hF, 32'hCAFE_F00D);
        // load, no ack: timeout after 16 WAIT cycles
        run_op(1, 0, 1, 1, 5'd9, 32'h110, 32'h0, 2'b10, 0,
               0, 32'h0, 0,
               32'h0, 1, 0, 0, 1, 17, 16, 0, 4'hF, 32'h0);
        // ack on the timeout cycle wins
        run_op(1, 0, 1, 1, 5'd10, 32'h114, 32'h0, 2'b10, 0,
               16, 32'h0BAD_F00D, 0,
               32'h0BAD_F00D, 1, 1, 0, 0, 17, 16, 0, 4'hF, 32'h0);
        // misaligned word load
        run_op(1, 0, 1, 1, 5'd11, 32'h102, 32'h0, 2'b10, 0,
               1, 32'h0, 0,
               32'h0, 1, 0, 1, 0, 0, 0, 0, 4'hF, 32'h0);
        // misaligned word store
        run_op(0, 1, 0, 1, 5'd12, 32'h106, 32'h5555_AAAA, 2'b10, 0,
               1, 32'h0, 0,
               32'h0, 1, 0, 1, 0, 0, 0, 0, 4'hF, 32'h0);
        // read and write together: store, memtoreg passed
        run_op(1, 1, 1, 0, 5'd13, 32'h108, 32'h1122_3344, 2'b10, 0,
               1, 32'h0, 0,
               32'h0, 0, 0, 0, 0, 2, 1, 1, 4'hF, 32'h1122_3344);
        // ack in IDLE ignored
        run_op(1, 0, 1, 1, 5'd14, 32'h118, 32'h0, 2'b10, 0,
               1, 32'h55AA_55AA, 1,
               32'h55AA_55AA, 1, 1, 0, 0, 2, 1, 0, 4'hF, 32'h0);
`ifdef MEM_BYTE_ACCESS_EN
        // signed byte load from top lane
        run_op(1, 0, 1, 1, 5'd15, 32'h203, 32'h0, 2'b00, 1,
               1, 32'h8000_0000, 0,
               32'hFFFF_FF80, 1, 1, 0, 0, 2, 1, 0, 4'b1000, 32'h0);
        // half store to upper half, data replicated
        run_op(0, 1, 0, 0, 5'd0, 32'h102, 32'h0000_BEEF, 2'b01, 0,
               1, 32'h0, 0,
               32'h0, 0, 0, 0, 0, 2, 1, 1, 4'b1100, 32'hBEEF_BEEF);
        // zero-extended half load
        run_op(1, 0, 1, 1, 5'd16, 32'h102, 32'h0, 2'b01, 0,
               1, 32'h8001_0000, 0,
               32'h0000_8001, 1, 1, 0, 0, 2, 1, 0, 4'b1100, 32'h0);
        // odd half address is misaligned
        run_op(1, 0, 1, 1, 5'd17, 32'h101, 32'h0, 2'b01, 0,
               1, 32'h0, 0,
               32'h0, 1, 0, 1, 0, 0, 0, 0, 4'hF, 32'h0);
`else
        // size ignored: byte at odd address is a misaligned word
        run_op(1, 0, 1, 1, 5'd15, 32'h203, 32'h0, 2'b00, 1,
               1, 32'h8000_0000, 0,
               32'h0, 1, 0, 1, 0, 0, 0, 0, 4'hF, 32'h0);
        // size/sign ignored: full word returned
        run_op(1, 0, 1, 1, 5'd16, 32'h200, 32'h0, 2'b00, 1,
               1, 32'h8000_0000, 0,
               32'h8000_0000, 1, 1, 0, 0, 2, 1, 0, 4'hF, 32'h0);
`endif
        // reset in the middle of WAIT
        @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        d_memread_i = 1'b1;
        d_regwrite_i = 1'b1;
        alu_result_i = 32'h300;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        chk("wait_req", {31'h0, mem.mem_req_o}, 32'h1);
        rst_i = 1'b0;
        #1;
        chk("rstw_req", {31'h0, mem.mem_req_o}, 32'h0);
        chk("rstw_stall", {31'h0, stall_o}, 32'h0);
        chk("rstw_we", {31'h0, mem.mem_we_o}, 32'h0);
        drive_nop();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        mon_en = 1'b1;
        // back in IDLE: normal load after reset
        run_op(1, 0, 1, 1, 5'd18, 32'h120, 32'h0, 2'b10, 0,
               1, 32'h1357_9BDF, 0,
               32'h1357_9BDF, 1, 1, 0, 0, 2, 1, 0, 4'hF, 32'h0);
        @(posedge clk_i);
        #1;
        drive_nop();
        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, WAIT-state cycles without mem_ack_i before the access is abandoned.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 d_memread_i / d_memwrite_i / d_memtoreg_i / d_regwrite_i  in  1 each  control bits from EX/MEM register.
REQ-005 regdst_i  in  5  destination register; alu_result_i  in  32  address or ALU value; write_data_i  in  32  store data.
REQ-006 size_i  in  2  00 byte, 01 half, 10 word; sign_ext_i  in  1  load sign-extend enable.
REQ-007 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32; mem_be_o  out  4  data-memory request.
REQ-008 mem_ack_i  in  1; mem_rdata_i  in  32  memory completion and read data.
REQ-009 stall_o  out  1  hold upstream registers (drives keep_i of PC/IF-ID/ID-EX/EX-MEM); high = hold.
REQ-010 d_memtoreg_o, d_regwrite_o  out  1; regdst_o  out  5; data_mem_o, alu_result_o  out  32  to MEM/WB register.
REQ-011 misalign_o, bus_err_o  out  1  single-cycle exception pulses.

Function
REQ-012 FSM states IDLE, WAIT, DONE; 5-bit timeout counter; 32-bit load buffer.
REQ-013 IDLE, no memread/memwrite: stall_o=0, mem_req_o=0, control/regdst/alu_result passed combinationally, data_mem_o=0, zero added latency.
REQ-014 IDLE, aligned access: stall_o=1 combinationally; next state WAIT; mem_req_o registered high from the following cycle.
REQ-015 WAIT: mem_req_o, mem_we_o(=memwrite), mem_addr_o(=alu_result_i), mem_wdata_o, mem_be_o held stable; stall_o=1; counter increments each cycle.
REQ-016 WAIT with mem_ack_i=1: capture formatted mem_rdata_i into buffer (loads only), drop mem_req_o next cycle, go DONE.
REQ-017 DONE: stall_o=0, data_mem_o=buffer, controls passed through; next state IDLE unconditionally (one cycle).
REQ-018 Minimum access latency: 3 cycles from entering IDLE with access to MEM/WB capture (IDLE, WAIT with ack, DONE).
REQ-019 Timeout: counter reaching TIMEOUT_CYCLES-1 with no ack -> bus_err_o=1 one cycle, buffer=0, go DONE; in that DONE d_regwrite_o forced 0.
REQ-020 ack arriving on the same cycle as timeout takes priority; no bus_err_o.
REQ-021 mem_ack_i outside WAIT is ignored.
REQ-022 Misaligned access (word addr[1:0]!=0; half addr[0]!=0): no request, no stall, misalign_o=1 that cycle, d_regwrite_o forced 0, store suppressed.
REQ-023 memread and memwrite both high: treated as store; d_memtoreg_o passed unchanged.

Reset
REQ-024 rst_i low asynchronously forces IDLE, counter=0, buffer=0, mem_req_o=0, mem_we_o=0, bus_err_o=0; reset during WAIT drops mem_req_o immediately.
REQ-025 Combinational outputs during reset follow REQ-013/014 from IDLE; stall_o=0 while rst_i low.

Configuration
REQ-026 Macro MEM_BYTE_ACCESS_EN.
REQ-027 Defined: size_i honoured; mem_be_o = lane mask (byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111); store data replicated across lanes; load data shifted to bit 0, sign- or zero-extended per sign_ext_i.
REQ-028 Undefined: size_i and sign_ext_i ignored; all accesses word; mem_be_o=4'hF; only word alignment checked.

Verification
REQ-029 Non-memory op, alu_result_i=0x12345678, regdst_i=5 -> same cycle alu_result_o=0x12345678, regdst_o=5, stall_o=0, mem_req_o never high.
REQ-030 Word load addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF -> stall_o high 3 cycles, DONE data_mem_o=0xDEADBEEF, stall_o=0.
REQ-031 Store addr 0x104 data 0xCAFEF00D, ack first WAIT cycle -> mem_we_o=1, mem_be_o=F, mem_wdata_o=0xCAFEF00D held until ack; total 3 cycles.
REQ-032 Load, no ack -> after 16 WAIT cycles bus_err_o pulse, data_mem_o=0, d_regwrite_o=0, FSM back to IDLE.
REQ-033 Word load addr 0x102 -> misalign_o=1, stall_o=0, mem_req_o=0, d_regwrite_o=0.
REQ-034 (MEM_BYTE_ACCESS_EN) byte load addr 0x203, sign_ext_i=1, rdata 0x80000000 -> mem_be_o=1000, data_mem_o=0xFFFFFF80; rst_i low mid-WAIT -> mem_req_o=0 immediately.
